led_frame_buffer: RTL and testbench

Double-buffered per-LED color store that sits directly upstream of `led_driver`. It answers the driver's `next_led_request`/`request_valid` with that LED's green/red/blue values and `color_valid`. It accepts random-access color writes from a host-side producer into a back bank, and swaps back and front banks only at a frame boundary, so a strand never shows a half-updated frame.

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_bank_ram.sv | 26 ++
 rtl/led_frame_buffer.sv | 139 +++++++++++++
 tb/tb_led_frame_buffer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED frame buffer: GRB colour struct, FSM state and index-width helper.
package led_pkg;

  localparam int LED_COLOR_W = 8;

  // Field order matches the wire order of the strand: green, then red, then blue
  typedef struct packed {
    logic [LED_COLOR_W-1:0] green;
    logic [LED_COLOR_W-1:0] red;
    logic [LED_COLOR_W-1:0] blue;
  } rgb_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_bank_ram.sv
// One colour bank: NUM_LEDS-deep memory, one synchronous write port, one registered read port.
module led_bank_ram #(
  parameter int DEPTH = 2,
  parameter int AW    = 1,
  parameter int DW    = 24
) (
  input  logic          clk_in,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk_in) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered per-LED colour store feeding led_driver; banks swap only at the end of a frame.
module led_frame_buffer
  import led_pkg::*;
#(
  parameter  int NUM_LEDS    = 2,
  parameter  int COLOR_WIDTH = 8,
  localparam int IDX_W       = idx_width(NUM_LEDS)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   wr_valid,
  input  logic [IDX_W-1:0]       wr_addr,
  input  logic [COLOR_WIDTH-1:0] wr_green,
  input  logic [COLOR_WIDTH-1:0] wr_red,
  input  logic [COLOR_WIDTH-1:0] wr_blue,
  input  logic                   commit_in,
  input  logic [IDX_W-1:0]       next_led_request,
  input  logic                   request_valid,
  output logic [COLOR_WIDTH-1:0] green_out,
  output logic [COLOR_WIDTH-1:0] red_out,
  output logic [COLOR_WIDTH-1:0] blue_out,
  output logic                   color_valid,
  output logic                   ready_out,
  output logic                   swap_done
);

  localparam int               DW       = 3 * COLOR_WIDTH;
  localparam logic [IDX_W:0]   NUM_W    = (IDX_W+1)'(NUM_LEDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

  fb_state_t        r_state;
  fb_state_t        w_state_next;
  logic [IDX_W-1:0] r_clr_idx;
  logic             r_front_sel;
  logic             r_swap_pending;
  logic             r_color_valid;
  logic             r_swap_done;
  logic             r_resp_zero;
  logic             r_resp_bank;

  logic             w_in_run;
  logic             w_clearing;
  logic             w_wr_in_range;
  logic             w_req_in_range;
  logic             w_swap;
  logic [DW-1:0]    w_wr_word;
  logic [DW-1:0]    w_sel_word;

  logic             w_we    [2];
  logic             w_re    [2];
  logic [IDX_W-1:0] w_waddr [2];
  logic [DW-1:0]    w_wdata [2];
  logic [DW-1:0]    w_rdata [2];

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == CLEAR) r_clr_idx <= r_clr_idx + IDX_W'(1);
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (r_clr_idx == LAST_IDX) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = CLEAR;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_in_run   = (r_state == RUN);
    w_clearing = (r_state == CLEAR);
    ready_out  = (r_state == RUN);
  end

  assign w_wr_in_range  = ({1'b0, wr_addr} < NUM_W);
  assign w_req_in_range = ({1'b0, next_led_request} < NUM_W);
  assign w_swap         = w_in_run && request_valid && r_swap_pending &&
                          (next_led_request == LAST_IDX);
  assign w_wr_word      = {wr_green, wr_red, wr_blue};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_color_valid  <= 1'b0;
      r_swap_done    <= 1'b0;
      r_resp_zero    <= 1'b1;
      r_resp_bank    <= 1'b0;
    end else begin
      r_color_valid  <= request_valid;
      r_swap_done    <= w_swap;
      // A commit landing on the swap cycle re-arms for the following frame
      r_swap_pending <= commit_in || (r_swap_pending && !w_swap);
      if (w_swap) r_front_sel <= !r_front_sel;
      if (request_valid) begin
        r_resp_zero <= !(w_in_run && w_req_in_range);
        r_resp_bank <= r_front_sel;
      end
    end
  end

  // Clearing writes both banks; in RUN only the back bank is written and only the front is read
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign w_we[gi]    = w_clearing ||
                         (w_in_run && wr_valid && w_wr_in_range && (r_front_sel != 1'(gi)));
    assign w_waddr[gi] = w_clearing ? r_clr_idx : wr_addr;
    assign w_wdata[gi] = w_clearing ? '0 : w_wr_word;
    assign w_re[gi]    = request_valid && w_in_run && w_req_in_range &&
                         (r_front_sel == 1'(gi));

    led_bank_ram #(
      .DEPTH(NUM_LEDS),
      .AW   (IDX_W),
      .DW   (DW)
    ) u_bank (
      .clk_in (clk_in),
      .i_we   (w_we[gi]),
      .i_waddr(w_waddr[gi]),
      .i_wdata(w_wdata[gi]),
      .i_re   (w_re[gi]),
      .i_raddr(next_led_request),
      .o_rdata(w_rdata[gi])
    );
  end

  assign w_sel_word = r_resp_bank ? w_rdata[1] : w_rdata[0];
  assign {green_out, red_out, blue_out} = r_resp_zero ? '0 : w_sel_word;
  assign color_valid = r_color_valid;
  assign swap_done   = r_swap_done;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Drives a 4-LED and a 3-LED frame buffer with shared stimulus and checks both against a frame-level model.
module tb_led_frame_buffer;
  import led_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_valid;
  logic [1:0] wr_addr;
  rgb_t       wr_col;
  logic       commit;
  logic       req;
  logic [1:0] req_idx;

  logic [7:0] g4, r4, b4, g3, r3, b3;
  logic       cv4, rdy4, sd4, cv3, rdy3, sd3;

  led_frame_buffer #(.NUM_LEDS(4), .COLOR_WIDTH(8)) d4 (
    .clk_in(clk), .rst_in(rst), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_green(wr_col.green), .wr_red(wr_col.red), .wr_blue(wr_col.blue),
    .commit_in(commit), .next_led_request(req_idx), .request_valid(req),
    .green_out(g4), .red_out(r4), .blue_out(b4),
    .color_valid(cv4), .ready_out(rdy4), .swap_done(sd4)
  );

  led_frame_buffer #(.NUM_LEDS(3), .COLOR_WIDTH(8)) d3 (
    .clk_in(clk), .rst_in(rst), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_green(wr_col.green), .wr_red(wr_col.red), .wr_blue(wr_col.blue),
    .commit_in(commit), .next_led_request(req_idx), .request_valid(req),
    .green_out(g3), .red_out(r3), .blue_out(b3),
    .color_valid(cv3), .ready_out(rdy3), .swap_done(sd3)
  );

  // Frame-level model, index 0 = 4-LED instance, index 1 = 3-LED instance
  logic [23:0] m_bank [2][2][4];
  int          m_cnt  [2];
  bit          m_fs   [2];
  bit          m_pend [2];
  bit          m_valid[2];
  bit          m_swap [2];
  logic [23:0] m_data [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    int n = (k == 0) ? 4 : 3;
    bit run;
    bit swp;
    if (rst) begin
      m_cnt[k] = 0; m_fs[k] = 0; m_pend[k] = 0;
      m_valid[k] = 0; m_swap[k] = 0; m_data[k] = '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 4; i++) m_bank[k][b][i] = '0;
    end else begin
      run = (m_cnt[k] >= n);
      m_valid[k] = req;
      if (req) m_data[k] = (run && int'(req_idx) < n) ? m_bank[k][m_fs[k]][req_idx] : '0;
      swp = run && req && (int'(req_idx) == n - 1) && m_pend[k];
      if (run && wr_valid && int'(wr_addr) < n) m_bank[k][!m_fs[k]][wr_addr] = wr_col;
      m_pend[k] = commit || (m_pend[k] && !swp);
      if (swp) m_fs[k] = !m_fs[k];
      m_swap[k] = swp;
      if (!run) m_cnt[k]++;
    end
  endtask

  task automatic check_all();
    check("valid4", 32'(cv4),  32'(m_valid[0]));
    check("swap4",  32'(sd4),  32'(m_swap[0]));
    check("ready4", 32'(rdy4), 32'(m_cnt[0] >= 4));
    check("data4",  {8'h0, g4, r4, b4}, {8'h0, m_data[0]});
    check("valid3", 32'(cv3),  32'(m_valid[1]));
    check("swap3",  32'(sd3),  32'(m_swap[1]));
    check("ready3", 32'(rdy3), 32'(m_cnt[1] >= 3));
    check("data3",  {8'h0, g3, r3, b3}, {8'h0, m_data[1]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    if (req || wr_valid || commit || rst)
      $display("t=%0t rst=%0b req=%0b idx=%0d wr=%0b addr=%0d col=%06h commit=%0b | d4 cv=%0b %06h sd=%0b rdy=%0b | d3 cv=%0b %06h sd=%0b rdy=%0b",
               $time, rst, req, req_idx, wr_valid, wr_addr, wr_col, commit,
               cv4, {g4, r4, b4}, sd4, rdy4, cv3, {g3, r3, b3}, sd3, rdy3);
    check_all();
  endtask

  task automatic drive(input bit rq, input int ri, input bit wv, input int wa,
                       input logic [23:0] col, input bit cm);
    req = rq; req_idx = 2'(ri); wr_valid = wv; wr_addr = 2'(wa);
    wr_col = col; commit = cm;
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    drive(0, 0, 0, 0, 24'h0, 0);
    #1;

    // Reset for three cycles, then measure time to ready with a request on the first cycle
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    drive(1, 0, 0, 0, 24'h0, 0);
    tick();
    check("clr_resp_valid", 32'(cv4), 32'd1);
    check("clr_resp_data", {8'h0, g4, r4, b4}, 32'h0);
    cnt = 1;
    drive(0, 0, 0, 0, 24'h0, 0);
    while (!rdy4 && cnt < 20) begin
      tick();
      cnt++;
      if (cnt == 3) check("ready3_at3", 32'(rdy3), 32'd1);
    end
    check("ready4_latency", 32'(cnt), 32'd4);

    // Write without commit leaves the front untouched
    drive(0, 0, 1, 2, 24'h123456, 0); tick();
    drive(1, 2, 0, 0, 24'h0, 0);      tick();
    check("no_commit_read", {8'h0, g4, r4, b4}, 32'h0);

    // Commit, walk a frame, expect the swap after the last LED
    drive(0, 0, 0, 0, 24'h0, 1); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, i, 0, 0, 24'h0, 0); tick();
    end
    check("swap_done4", 32'(sd4), 32'd1);
    drive(1, 2, 0, 0, 24'h0, 0); tick();
    check("swap_read4", {8'h0, g4, r4, b4}, 32'h123456);
    check("swap_read3", {8'h0, g3, r3, b3}, 32'h123456);

    // Full-throughput requests
    for (int i = 0; i < 8; i++) begin
      drive(1, i % 4, 0, 0, 24'h0, 0); tick();
      check("thru_valid4", 32'(cv4), 32'd1);
    end

    // Write in the same cycle as the swap-triggering request
    drive(0, 0, 0, 0, 24'h0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, i, 0, 0, 24'h0, 0); tick();
    end
    drive(1, 3, 1, 1, 24'hFFFFFF, 0); tick();
    check("sim_swap_done4", 32'(sd4), 32'd1);
    drive(1, 1, 0, 0, 24'h0, 0); tick();
    check("sim_write_read4", {8'h0, g4, r4, b4}, 32'hFFFFFF);

    // Out-of-range write and read on the 3-LED instance
    drive(0, 0, 1, 3, 24'hABCDEF, 0); tick();
    drive(1, 3, 0, 0, 24'h0, 0);      tick();
    check("oor_read3", {8'h0, g3, r3, b3}, 32'h0);

    // Reset with a swap pending abandons it
    drive(0, 0, 0, 0, 24'h0, 1); tick();
    rst = 1'b1;
    drive(1, 3, 0, 0, 24'h0, 0); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2, 1, 1, 24'h777777, 0); tick();
      check("rst_no_swap3", 32'(sd3), 32'd0);
      check("rst_clear_data3", {8'h0, g3, r3, b3}, 32'h0);
      if (i < 2) check("rst_not_ready3", 32'(rdy3), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, i, 0, 0, 24'h0, 0); tick();
      check("post_rst_no_swap4", 32'(sd4), 32'd0);
      check("post_rst_data4", {8'h0, g4, r4, b4}, 32'h0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
            24'($urandom), $urandom_range(0, 11) == 0);
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 24'h0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
